// File: rtl/fpnew_opgroup_ordered_arbiter_pkg.sv
// Shared widths and helpers for the opgroup ordered result arbiter.
// Optional head-of-line stall counter is enabled by defining FPNEW_ORDER_STALL_CNT_EN.
package fpnew_opgroup_ordered_arbiter_pkg;

    localparam int unsigned StallCntWidth = 16;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w > 0) ? w : 1;
    endfunction

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return idx_width(n + 1);
    endfunction

endpackage

// File: rtl/fpnew_opgroup_ordered_arbiter_order_fifo.sv
// Slice-index FIFO recording issue order; pointers wrap at Depth, which need not be a power of two.
module fpnew_opgroup_ordered_arbiter_order_fifo
    import fpnew_opgroup_ordered_arbiter_pkg::*;
#(
    parameter int unsigned Depth    = 4,
    parameter int unsigned IdxWidth = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                push_i,
    input  logic [IdxWidth-1:0] data_i,
    input  logic                pop_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [IdxWidth-1:0] head_o
);

    localparam int unsigned PtrWidth = idx_width(Depth);
    localparam int unsigned CntWidth = cnt_width(Depth);

    logic [IdxWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0] wr_q;
    logic [PtrWidth-1:0] rd_q;
    logic [CntWidth-1:0] cnt_q;
    logic                push_ok;
    logic                pop_ok;

    assign full_o  = (32'(cnt_q) == Depth);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem[rd_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
        return (32'(p) >= Depth - 1) ? '0 : p + PtrWidth'(1);
    endfunction

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= ptr_next(wr_q);
            end
            if (pop_ok) begin
                rd_q <= ptr_next(rd_q);
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - CntWidth'(1);
            end
        end
    end

endmodule

// File: rtl/fpnew_opgroup_ordered_arbiter.sv
// Opgroup output arbiter: retires slice results in issue order (InOrder=1) or round-robin (InOrder=0).
// Define FPNEW_ORDER_STALL_CNT_EN to build the saturating head-of-line stall counter.
module fpnew_opgroup_ordered_arbiter
    import fpnew_opgroup_ordered_arbiter_pkg::*;
#(
    parameter int unsigned NumSlices  = 5,
    parameter int unsigned DataWidth  = 38,
    parameter int unsigned OrderDepth = 4,
    parameter bit          InOrder    = 1'b1,
    parameter int unsigned IdxWidth   = idx_width(NumSlices)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           issue_valid_i,
    input  logic [IdxWidth-1:0]            issue_slice_i,
    output logic                           issue_ready_o,
    input  logic [NumSlices*DataWidth-1:0] slc_data_i,
    input  logic [NumSlices-1:0]           slc_valid_i,
    output logic [NumSlices-1:0]           slc_ready_o,
    output logic [DataWidth-1:0]           out_data_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic                           busy_o,
    output logic [StallCntWidth-1:0]       stall_cnt_o
);

    localparam int unsigned CntWidth = cnt_width(OrderDepth);

    logic [DataWidth-1:0] slc_data [NumSlices];
    logic [CntWidth-1:0]  inflight_q;
    logic [IdxWidth-1:0]  sel_idx;
    logic                 hold;
    logic                 slice_ok;
    logic                 issue_fire;
    logic                 retire;

    for (genvar g = 0; g < NumSlices; g++) begin : g_unpack
        assign slc_data[g] = slc_data_i[g*DataWidth +: DataWidth];
    end

    assign hold          = rst_i | flush_i;
    assign slice_ok      = (32'(issue_slice_i) < NumSlices);
    assign issue_ready_o = ~hold & (32'(inflight_q) < OrderDepth);
    assign issue_fire    = issue_valid_i & issue_ready_o & slice_ok;
    assign retire        = out_valid_o & out_ready_i;
    assign busy_o        = (inflight_q != '0);

    // In-flight count gates issue; a same-cycle retire is not bypassed into issue_ready_o.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            inflight_q <= '0;
        end else if (issue_fire && !retire) begin
            inflight_q <= inflight_q + CntWidth'(1);
        end else if (retire && !issue_fire && (inflight_q != '0)) begin
            inflight_q <= inflight_q - CntWidth'(1);
        end
    end

    always_comb begin
        out_data_o = slc_data[0];
        for (int unsigned i = 1; i < NumSlices; i++) begin
            if (sel_idx == IdxWidth'(i)) begin
                out_data_o = slc_data[i];
            end
        end
    end

    a_issue_slice_range: assert property (@(posedge clk_i) disable iff (rst_i)
        (issue_valid_i && issue_ready_o) |-> slice_ok);

`ifdef FPNEW_ORDER_STALL_CNT_EN
    logic                     stall_c;
    logic [StallCntWidth-1:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            stall_cnt_q <= '0;
        end else if (stall_c && (stall_cnt_q != {StallCntWidth{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + StallCntWidth'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

    if (InOrder) begin : g_ordered
        logic                fifo_full;
        logic                fifo_empty;
        logic [IdxWidth-1:0] head;
        logic                head_valid;

        fpnew_opgroup_ordered_arbiter_order_fifo #(
            .Depth    (OrderDepth),
            .IdxWidth (IdxWidth)
        ) i_order_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (flush_i),
            .push_i  (issue_fire),
            .data_i  (issue_slice_i),
            .pop_i   (retire),
            .full_o  (fifo_full),
            .empty_o (fifo_empty),
            .head_o  (head)
        );

        // Only the slice that holds the oldest in-flight op may hand over its result.
        always_comb begin
            head_valid  = 1'b0;
            slc_ready_o = '0;
            for (int unsigned i = 0; i < NumSlices; i++) begin
                if (head == IdxWidth'(i)) begin
                    head_valid     = slc_valid_i[i];
                    slc_ready_o[i] = ~hold & ~fifo_empty & out_ready_i;
                end
            end
        end

        assign sel_idx     = head;
        assign out_valid_o = ~hold & ~fifo_empty & head_valid;

`ifdef FPNEW_ORDER_STALL_CNT_EN
        logic other_valid;

        always_comb begin
            other_valid = 1'b0;
            for (int unsigned i = 0; i < NumSlices; i++) begin
                if (head != IdxWidth'(i)) begin
                    other_valid = other_valid | slc_valid_i[i];
                end
            end
        end

        assign stall_c = ~fifo_empty & ~head_valid & other_valid;
`endif

        a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
            issue_fire |-> !fifo_full);
    end else begin : g_round_robin
        logic [IdxWidth-1:0] rr_q;
        logic [IdxWidth-1:0] grant;
        logic [IdxWidth-1:0] grant_hi;
        logic [IdxWidth-1:0] grant_lo;
        logic                found_hi;
        logic                found_lo;

        // First valid slice at or above the pointer wins, else the first one below it.
        always_comb begin
            grant_hi = rr_q;
            grant_lo = rr_q;
            found_hi = 1'b0;
            found_lo = 1'b0;
            for (int unsigned i = 0; i < NumSlices; i++) begin
                if (slc_valid_i[i]) begin
                    if (i >= 32'(rr_q)) begin
                        if (!found_hi) begin
                            grant_hi = IdxWidth'(i);
                            found_hi = 1'b1;
                        end
                    end else if (!found_lo) begin
                        grant_lo = IdxWidth'(i);
                        found_lo = 1'b1;
                    end
                end
            end
            grant = found_hi ? grant_hi : (found_lo ? grant_lo : rr_q);
        end

        always_comb begin
            slc_ready_o = '0;
            for (int unsigned i = 0; i < NumSlices; i++) begin
                if (grant == IdxWidth'(i)) begin
                    slc_ready_o[i] = ~hold & out_ready_i;
                end
            end
        end

        assign sel_idx     = grant;
        assign out_valid_o = ~hold & (|slc_valid_i);

        // Pointer moves only on retire so the grant stays put under backpressure.
        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                rr_q <= '0;
            end else if (retire) begin
                rr_q <= (32'(grant) >= NumSlices - 1) ? '0 : grant + IdxWidth'(1);
            end
        end

`ifdef FPNEW_ORDER_STALL_CNT_EN
        assign stall_c = 1'b0;
`endif

        a_no_retire_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
            retire |-> (inflight_q != '0));
    end

endmodule

// File: tb/tb_fpnew_opgroup_ordered_arbiter.sv
// Directed bench: one in-order and one round-robin arbiter instance, three slices each.
module tb_fpnew_opgroup_ordered_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // In-order instance (a) and round-robin instance (b)
    logic        flush_a = 0, iv_a = 0, ir_a, or_a = 0, ov_a, busy_a;
    logic [1:0]  is_a = 0;
    logic [2:0]  sv_a = 0, sr_a;
    logic [7:0]  od_a;
    logic [15:0] stall_a;
    logic        flush_b = 0, iv_b = 0, ir_b, or_b = 0, ov_b, busy_b;
    logic [1:0]  is_b = 0;
    logic [2:0]  sv_b = 0, sr_b;
    logic [7:0]  od_b;
    logic [15:0] stall_b;
    logic [23:0] payload = {8'hC2, 8'hB1, 8'hA0};

    fpnew_opgroup_ordered_arbiter #(
        .NumSlices(3), .DataWidth(8), .OrderDepth(4), .InOrder(1'b1)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .issue_valid_i(iv_a), .issue_slice_i(is_a),
        .issue_ready_o(ir_a), .slc_data_i(payload), .slc_valid_i(sv_a), .slc_ready_o(sr_a),
        .out_data_o(od_a), .out_valid_o(ov_a), .out_ready_i(or_a), .busy_o(busy_a),
        .stall_cnt_o(stall_a)
    );

    fpnew_opgroup_ordered_arbiter #(
        .NumSlices(3), .DataWidth(8), .OrderDepth(4), .InOrder(1'b0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .issue_valid_i(iv_b), .issue_slice_i(is_b),
        .issue_ready_o(ir_b), .slc_data_i(payload), .slc_valid_i(sv_b), .slc_ready_o(sr_b),
        .out_data_o(od_b), .out_valid_o(ov_b), .out_ready_i(or_b), .busy_o(busy_b),
        .stall_cnt_o(stall_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sv_a = 3'b111; or_a = 1'b1; sv_b = 3'b111; or_b = 1'b1;
        tick(); tick(); #1;
        check_cnt++; if (ir_a !== 1'b0) $display("FAIL reset_issue_ready_a got %b want 0", ir_a); else pass_cnt++;
        check_cnt++; if (ov_a !== 1'b0) $display("FAIL reset_out_valid_a got %b want 0", ov_a); else pass_cnt++;
        check_cnt++; if (sr_a !== 3'b000) $display("FAIL reset_slc_ready_a got %b want 000", sr_a); else pass_cnt++;
        check_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy_a got %b want 0", busy_a); else pass_cnt++;
        check_cnt++; if (ov_b !== 1'b0 || sr_b !== 3'b000) $display("FAIL reset_out_b got valid=%b ready=%b want 0/000", ov_b, sr_b); else pass_cnt++;
        check_cnt++; if (stall_a !== 16'h0) $display("FAIL reset_stall got %h want 0000", stall_a); else pass_cnt++;
        sv_a = 0; or_a = 0; sv_b = 0; or_b = 0;
        tick(); rst = 1'b0;
        tick(); #1;
        check_cnt++; if (ir_a !== 1'b1) $display("FAIL post_reset_issue_ready got %b want 1", ir_a); else pass_cnt++;
    endtask

    task automatic test_in_order();
        iv_a = 1; is_a = 2; tick();
        is_a = 0; tick();
        iv_a = 0; sv_a = 3'b001; or_a = 1; #1;
        check_cnt++; if (ov_a !== 1'b0) $display("FAIL order_younger_held got %b want 0", ov_a); else pass_cnt++;
        check_cnt++; if (sr_a !== 3'b100) $display("FAIL order_ready_head_only got %b want 100", sr_a); else pass_cnt++;
        check_cnt++; if (busy_a !== 1'b1) $display("FAIL order_busy got %b want 1", busy_a); else pass_cnt++;
        tick(); tick(); #1;
        check_cnt++; if (ov_a !== 1'b0 || sr_a[0] !== 1'b0) $display("FAIL order_still_held got valid=%b ready=%b", ov_a, sr_a); else pass_cnt++;
        sv_a = 3'b101; #1;
        check_cnt++; if (ov_a !== 1'b1 || od_a !== 8'hC2) $display("FAIL order_first_retire got valid=%b data=%h want 1/c2", ov_a, od_a); else pass_cnt++;
        tick();
        sv_a = 3'b001; #1;
        check_cnt++; if (ov_a !== 1'b1 || od_a !== 8'hA0 || sr_a !== 3'b001) $display("FAIL order_second_retire got %b/%h/%b want 1/a0/001", ov_a, od_a, sr_a); else pass_cnt++;
        tick();
        sv_a = 3'b111; #1;
        check_cnt++; if (ov_a !== 1'b0 || sr_a !== 3'b000 || busy_a !== 1'b0) $display("FAIL order_empty got %b/%b/%b want 0/000/0", ov_a, sr_a, busy_a); else pass_cnt++;
        sv_a = 0; or_a = 0;
    endtask

    task automatic test_throttle();
        logic [7:0] exp_data [4];
        exp_data = '{8'hB1, 8'hC2, 8'hA0, 8'hB1};
        iv_a = 1; is_a = 0; #1;
        check_cnt++; if (ir_a !== 1'b1) $display("FAIL throttle_open got %b want 1", ir_a); else pass_cnt++;
        tick(); is_a = 1; tick(); is_a = 2; tick(); is_a = 0; tick();
        is_a = 1; #1;
        check_cnt++; if (ir_a !== 1'b0) $display("FAIL throttle_full got %b want 0", ir_a); else pass_cnt++;
        sv_a = 3'b001; or_a = 1; #1;
        check_cnt++; if (ov_a !== 1'b1 || ir_a !== 1'b0) $display("FAIL throttle_no_bypass got valid=%b ready=%b want 1/0", ov_a, ir_a); else pass_cnt++;
        tick();
        sv_a = 3'b000; #1;
        check_cnt++; if (ir_a !== 1'b1) $display("FAIL throttle_reopen got %b want 1", ir_a); else pass_cnt++;
        tick();
        iv_a = 0; #1;
        check_cnt++; if (ir_a !== 1'b0) $display("FAIL throttle_refull got %b want 0", ir_a); else pass_cnt++;
        sv_a = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_cnt++; if (od_a !== exp_data[k]) $display("FAIL throttle_drain_%0d got %h want %h", k, od_a, exp_data[k]); else pass_cnt++;
            tick();
        end
        #1;
        check_cnt++; if (busy_a !== 1'b0) $display("FAIL throttle_drained_busy got %b want 0", busy_a); else pass_cnt++;
        sv_a = 0; or_a = 0;
    endtask

    task automatic test_flush();
        iv_a = 1; is_a = 0; tick(); is_a = 1; tick(); is_a = 2; tick();
        iv_a = 0; flush_a = 1; sv_a = 3'b001; or_a = 1; #1;
        check_cnt++; if (ir_a !== 1'b0 || ov_a !== 1'b0 || sr_a !== 3'b000) $display("FAIL flush_outputs got %b/%b/%b want 0/0/000", ir_a, ov_a, sr_a); else pass_cnt++;
        tick();
        flush_a = 0; #1;
        check_cnt++; if (busy_a !== 1'b0 || ov_a !== 1'b0) $display("FAIL flush_cleared got busy=%b valid=%b want 0/0", busy_a, ov_a); else pass_cnt++;
        iv_a = 1; is_a = 1; sv_a = 0; tick();
        iv_a = 0; sv_a = 3'b010; #1;
        check_cnt++; if (ov_a !== 1'b1 || od_a !== 8'hB1 || sr_a !== 3'b010) $display("FAIL flush_new_issue got %b/%h/%b want 1/b1/010", ov_a, od_a, sr_a); else pass_cnt++;
        tick(); #1;
        check_cnt++; if (busy_a !== 1'b0) $display("FAIL flush_new_retired got %b want 0", busy_a); else pass_cnt++;
        sv_a = 0; or_a = 0;
    endtask

    task automatic test_stall_cnt();
        flush_a = 1; tick(); flush_a = 0;
        iv_a = 1; is_a = 1; tick();
        iv_a = 0; sv_a = 3'b001;
        repeat (10) tick();
        #1;
`ifdef FPNEW_ORDER_STALL_CNT_EN
        check_cnt++; if (stall_a !== 16'd10) $display("FAIL stall_ten got %0d want 10", stall_a); else pass_cnt++;
        repeat (70000) tick();
        #1;
        check_cnt++; if (stall_a !== 16'hFFFF) $display("FAIL stall_saturate got %h want ffff", stall_a); else pass_cnt++;
`else
        check_cnt++; if (stall_a !== 16'h0000) $display("FAIL stall_tied_off got %h want 0000", stall_a); else pass_cnt++;
`endif
        flush_a = 1; tick(); flush_a = 0; #1;
        check_cnt++; if (stall_a !== 16'h0000 || busy_a !== 1'b0) $display("FAIL stall_flush got %h/%b want 0000/0", stall_a, busy_a); else pass_cnt++;
        sv_a = 0;
    endtask

    task automatic test_reset_mid();
        iv_a = 1; is_a = 0; tick(); is_a = 2; tick();
        iv_a = 0; #1;
        check_cnt++; if (busy_a !== 1'b1) $display("FAIL rstmid_busy_before got %b want 1", busy_a); else pass_cnt++;
        rst = 1; sv_a = 3'b111; or_a = 1; #1;
        check_cnt++; if (ov_a !== 1'b0) $display("FAIL rstmid_valid_held got %b want 0", ov_a); else pass_cnt++;
        tick();
        rst = 0; #1;
        check_cnt++; if (busy_a !== 1'b0 || ov_a !== 1'b0 || ir_a !== 1'b1 || stall_a !== 16'h0) $display("FAIL rstmid_after got busy=%b valid=%b ready=%b stall=%h", busy_a, ov_a, ir_a, stall_a); else pass_cnt++;
        sv_a = 0; or_a = 0;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_data [4];
        logic [2:0] exp_rdy [4];
        exp_data = '{8'hA0, 8'hB1, 8'hC2, 8'hA0};
        exp_rdy  = '{3'b001, 3'b010, 3'b100, 3'b001};
        iv_b = 1; is_b = 0; tick(); is_b = 1; tick(); is_b = 2; tick(); is_b = 0; tick();
        iv_b = 0; sv_b = 3'b111; or_b = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_cnt++; if (ov_b !== 1'b1 || od_b !== exp_data[k] || sr_b !== exp_rdy[k]) $display("FAIL rr_grant_%0d got %b/%h/%b want 1/%h/%b", k, ov_b, od_b, sr_b, exp_data[k], exp_rdy[k]); else pass_cnt++;
            tick();
        end
        or_b = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_cnt++; if (ov_b !== 1'b1 || od_b !== 8'hB1 || sr_b !== 3'b000) $display("FAIL rr_hold_%0d got %b/%h/%b want 1/b1/000", k, ov_b, od_b, sr_b); else pass_cnt++;
            tick();
        end
        check_cnt++; if (busy_b !== 1'b0) $display("FAIL rr_busy_drained got %b want 0", busy_b); else pass_cnt++;
        sv_b = 0;
    endtask

    task automatic test_rr_reset_mid();
        iv_b = 1; is_b = 2; tick(); is_b = 1; tick();
        iv_b = 0; sv_b = 3'b111; or_b = 0; #1;
        check_cnt++; if (od_b !== 8'hB1 || busy_b !== 1'b1) $display("FAIL rr_rstmid_before got %h/%b want b1/1", od_b, busy_b); else pass_cnt++;
        rst = 1; tick();
        rst = 0; #1;
        check_cnt++; if (od_b !== 8'hA0 || busy_b !== 1'b0 || ir_b !== 1'b1) $display("FAIL rr_rstmid_after got %h/%b/%b want a0/0/1", od_b, busy_b, ir_b); else pass_cnt++;
        sv_b = 0;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_throttle();
        test_flush();
        test_stall_cnt();
        test_reset_mid();
        test_round_robin();
        test_rr_reset_mid();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
